nios_sys_dpram: RTL

//  Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) on one clock.

---
 rtl/nios_sys_dpram_pkg.sv | 17 +
 rtl/nios_sys_dpram_core.sv | 39 +++
 rtl/nios_sys_dpram.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/nios_sys_dpram_pkg.sv
// nios_sys_dpram shared types, widths and byte-lane helper.
package nios_sys_dpram_pkg;

   typedef enum logic {CLEAR, READY} state_e;

   localparam int COLL_CNT_W = 16;
   localparam int BE_MAX_W   = 16;

   // Lanes of the low-priority port that survive once the winner's lanes are removed.
   function automatic logic [BE_MAX_W-1:0] be_merge(
      input logic [BE_MAX_W-1:0] be_hi,
      input logic [BE_MAX_W-1:0] be_lo
   );
      return be_lo & ~be_hi;
   endfunction

endpackage

// File: rtl/nios_sys_dpram_core.sv
// nios_sys_dpram_core: true dual-port byte-enabled RAM array.
// Registered, read-before-write outputs; shaped for block RAM inference.
module nios_sys_dpram_core #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic                clk,
   input  logic [ADDR_W-1:0]   a_addr_i,
   input  logic [DATA_W/8-1:0] a_we_i,
   input  logic [DATA_W-1:0]   a_wdata_i,
   input  logic                a_re_i,
   output logic [DATA_W-1:0]   a_rdata_o,
   input  logic [ADDR_W-1:0]   b_addr_i,
   input  logic [DATA_W/8-1:0] b_we_i,
   input  logic [DATA_W-1:0]   b_wdata_i,
   input  logic                b_re_i,
   output logic [DATA_W-1:0]   b_rdata_o
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] a_rdata_q;
   logic [DATA_W-1:0] b_rdata_q;

   always_ff @(posedge clk) begin
      if (a_re_i) a_rdata_q <= mem_q[a_addr_i];
      if (b_re_i) b_rdata_q <= mem_q[b_addr_i];
      for (int i = 0; i < NB; i++) begin
         if (a_we_i[i]) mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
         if (b_we_i[i]) mem_q[b_addr_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
      end
   end

   assign a_rdata_o = a_rdata_q;
   assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/nios_sys_dpram.sv
// nios_sys_dpram: dual Avalon-MM slave shared RAM with clear-after-reset,
// pipelined reads, collision merge/forwarding and a collision counter.
module nios_sys_dpram
   import nios_sys_dpram_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 9,
   parameter int READ_LATENCY   = 1,
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter bit PRIORITY_S1    = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_W-1:0]     writedata,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid,
   output logic                  waitrequest,
   input  logic [ADDR_W-1:0]     address2,
   input  logic [DATA_W/8-1:0]   byteenable2,
   input  logic                  chipselect2,
   input  logic                  read2,
   input  logic                  write2,
   input  logic [DATA_W-1:0]     writedata2,
   output logic [DATA_W-1:0]     readdata2,
   output logic                  readdatavalid2,
   output logic                  waitrequest2,
   output logic [COLL_CNT_W-1:0] collision_count
);

   localparam int NB = DATA_W / 8;
   localparam logic [COLL_CNT_W-1:0] CNT_MAX = '1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
   logic                ready, clearing, same, ww, rw;
   logic [1:0]          wacc, racc, vld_q, out_v;
   logic [NB-1:0]       be_w [2];
   logic [NB-1:0]       fwd_be_q [2];
   logic [DATA_W-1:0]   fwd_d_q [2];
   logic [DATA_W-1:0]   core_rd [2];
   logic [DATA_W-1:0]   rdat [2];
   logic [DATA_W-1:0]   out_d [2];
   logic [DATA_W-1:0]   hold_q [2];
   logic [NB-1:0]       a_we;
   logic [ADDR_W-1:0]   a_addr;
   logic [DATA_W-1:0]   a_wd;
   logic [COLL_CNT_W-1:0] coll_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      unique case (state_q)
         CLEAR: begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (&clr_ptr_q) state_d = READY;
         end
         READY: ;
      endcase
   end

   assign ready    = (state_q == READY) && !reset;
   assign clearing = (state_q == CLEAR) && !reset;

   assign wacc[0] = chipselect & write & ready;
   assign racc[0] = chipselect & read & ~write & ready;
   assign wacc[1] = chipselect2 & write2 & ready;
   assign racc[1] = chipselect2 & read2 & ~write2 & ready;

   assign same = (address == address2);
   assign ww   = wacc[0] & wacc[1] & same;
   assign rw   = same & ((wacc[0] & racc[1]) | (racc[0] & wacc[1]));

   // On a write/write hit the losing port keeps only lanes the winner left alone.
   always_comb begin
      be_w[0] = wacc[0] ? byteenable  : '0;
      be_w[1] = wacc[1] ? byteenable2 : '0;
      if (ww && PRIORITY_S1)
         be_w[1] = NB'(be_merge(BE_MAX_W'(byteenable), BE_MAX_W'(byteenable2)));
      else if (ww)
         be_w[0] = NB'(be_merge(BE_MAX_W'(byteenable2), BE_MAX_W'(byteenable)));
   end

   assign a_we   = clearing ? '1 : be_w[0];
   assign a_addr = clearing ? clr_ptr_q : address;
   assign a_wd   = clearing ? '0 : writedata;

   nios_sys_dpram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk       (clk),
      .a_addr_i  (a_addr),
      .a_we_i    (a_we),
      .a_wdata_i (a_wd),
      .a_re_i    (racc[0]),
      .a_rdata_o (core_rd[0]),
      .b_addr_i  (address2),
      .b_we_i    (be_w[1]),
      .b_wdata_i (writedata2),
      .b_re_i    (racc[1]),
      .b_rdata_o (core_rd[1])
   );

   // The array returns pre-write data, so same-cycle writes from the other port are overlaid.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdat[p] = core_rd[p];
         for (int i = 0; i < NB; i++)
            if (fwd_be_q[p][i]) rdat[p][8*i +: 8] = fwd_d_q[p][8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q  <= '0;
         coll_q <= '0;
         for (int p = 0; p < 2; p++) begin
            hold_q[p]   <= '0;
            fwd_be_q[p] <= '0;
         end
      end else begin
         vld_q       <= racc;
         fwd_be_q[0] <= (racc[0] & wacc[1] & same) ? byteenable2 : '0;
         fwd_be_q[1] <= (racc[1] & wacc[0] & same) ? byteenable  : '0;
         if ((ww | rw) && coll_q != CNT_MAX) coll_q <= coll_q + COLL_CNT_W'(1);
         for (int p = 0; p < 2; p++)
            if (out_v[p]) hold_q[p] <= out_d[p];
      end
      fwd_d_q[0] <= writedata2;
      fwd_d_q[1] <= writedata;
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd
      if (READ_LATENCY == 2) begin : g_l2
         logic              v2_q;
         logic [DATA_W-1:0] d2_q;
         always_ff @(posedge clk) begin
            if (reset) v2_q <= 1'b0;
            else       v2_q <= vld_q[p];
            d2_q <= rdat[p];
         end
         assign out_v[p] = v2_q;
         assign out_d[p] = d2_q;
      end else begin : g_l1
         assign out_v[p] = vld_q[p];
         assign out_d[p] = rdat[p];
      end
   end

   assign readdata        = out_v[0] ? out_d[0] : hold_q[0];
   assign readdata2       = out_v[1] ? out_d[1] : hold_q[1];
   assign readdatavalid   = out_v[0];
   assign readdatavalid2  = out_v[1];
   assign waitrequest     = ~ready;
   assign waitrequest2    = ~ready;
   assign collision_count = coll_q;

endmodule
